// File: rtl/seq_det_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : seq_det_pkg
//  Brief    : Shared types and helpers for the programmable sequence detector
//  Revision : 1.0  initial release
// ============================================================================
package seq_det_pkg;

  // Width of the generic mask helper; callers size-cast down to MAX_LEN,
  // so MAX_LEN must not exceed this value.
  localparam int MASK_W = 32;

  typedef enum logic [1:0] {
    UNCFG = 2'd0,  // no valid pattern loaded
    FILL  = 2'd1,  // fewer than len bits collected
    RUN   = 2'd2,  // window full, no match
    HIT   = 2'd3   // window matches pattern
  } state_e;

  // Mask with the low 'len' bits set.
  function automatic logic [MASK_W-1:0] len_mask(input int unsigned len);
    if (len >= MASK_W) return '1;
    return (MASK_W'(1) << len) - MASK_W'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/seq_det_hist.sv
`default_nettype none
// ============================================================================
//  Module   : seq_det_hist
//  Brief    : Serial history shift register with saturating fill counter.
//             Exposes the post-sample history and fill-complete flag so the
//             caller can decide on a match in the same cycle.
//  Revision : 1.0  initial release
// ============================================================================
module seq_det_hist #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clr,      // discard history and fill
  input  logic               en,       // consume one bit
  input  logic               drop,     // with en: restart fill after this sample
  input  logic               a,
  input  logic [LEN_W-1:0]   len,
  output logic [MAX_LEN-1:0] hist_nx,
  output logic               full_nx
);

  // Only MAX_LEN-1 bits need storing: the oldest bit of a full window is
  // always shifted out before it can take part in another compare.
  logic [MAX_LEN-2:0] r_hist;
  logic [LEN_W-1:0]   r_fill;
  logic [LEN_W-1:0]   w_fill_nx;

  // Post-sample view of the window; fill saturates at the pattern length.
  always_comb begin
    hist_nx   = {r_hist, a};
    w_fill_nx = (r_fill >= len) ? len : r_fill + LEN_W'(1);
    full_nx   = (w_fill_nx == len);
  end

  // History and fill registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hist <= '0;
      r_fill <= '0;
    end else if (clr) begin
      r_hist <= '0;
      r_fill <= '0;
    end else if (en) begin
      r_hist <= hist_nx[MAX_LEN-2:0];
      r_fill <= drop ? '0 : w_fill_nx;
    end
  end

endmodule
`default_nettype wire

// File: rtl/seq_detector_param.sv
`default_nettype none
// ============================================================================
//  Module   : seq_detector_param
//  Brief    : Runtime-programmable Moore serial sequence detector with
//             overlapping / non-overlapping modes and a saturating hit count.
//             MAX_LEN is limited to seq_det_pkg::MASK_W (32).
//  Revision : 1.0  initial release
// ============================================================================
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter  int MAX_LEN = 8,
  parameter  int CNT_W   = 16,
  localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               a,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  output logic               y,
  output logic [CNT_W-1:0]   hit_count,
  output logic               cfg_err
);

  state_e             r_state;
  state_e             w_state_nx;
  logic [MAX_LEN-1:0] r_pattern;
  logic [LEN_W-1:0]   r_len;
  logic               r_overlap;

  logic [MAX_LEN-1:0] w_hist_nx;
  logic               w_full_nx;
  logic [MAX_LEN-1:0] w_mask;
  logic               w_sample;
  logic               w_match;
  logic               w_drop;
  logic               w_cfg_ok;

  seq_det_hist #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_hist (
    .clk     (clk),
    .reset   (reset),
    .clr     (cfg_load),
    .en      (w_sample),
    .drop    (w_drop),
    .a       (a),
    .len     (r_len),
    .hist_nx (w_hist_nx),
    .full_nx (w_full_nx)
  );

  // Sample qualification, masked compare and next-state selection.
  always_comb begin
    w_sample   = en && (r_state != UNCFG) && !cfg_load;
    w_mask     = MAX_LEN'(len_mask(32'(r_len)));
    w_match    = w_full_nx && (((w_hist_nx ^ r_pattern) & w_mask) == '0);
    // Non-overlap: a hit restarts the fill so the next match needs len fresh bits.
    w_drop     = w_match && !r_overlap;
    w_cfg_ok   = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
    w_state_nx = r_state;
    if (cfg_load) begin
      w_state_nx = w_cfg_ok ? FILL : UNCFG;
    end else if (w_sample) begin
      if (w_match)        w_state_nx = HIT;
      else if (w_full_nx) w_state_nx = RUN;
      else                w_state_nx = FILL;
    end
  end

  // State, configuration, registered Moore output and saturating hit counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= UNCFG;
      r_pattern <= '0;
      r_len     <= '0;
      r_overlap <= 1'b0;
      y         <= 1'b0;
      hit_count <= '0;
      cfg_err   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      y       <= (w_state_nx == HIT);
      if (cfg_load) begin
        r_pattern <= cfg_pattern;
        r_len     <= cfg_len;
        r_overlap <= cfg_overlap;
        hit_count <= '0;
        cfg_err   <= !w_cfg_ok;
      end else if (w_sample && w_match && !(&hit_count)) begin
        hit_count <= hit_count + CNT_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seq_detector_param.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_detector_param
//  Brief    : Self-checking bench for seq_detector_param. Two instances share
//             stimulus: a 16-bit counter build and a 2-bit counter build to
//             exercise saturation. Expectations come from a bit-queue model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_seq_detector_param;

  localparam int MAX_LEN = 8;
  localparam int LEN_W   = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             en = 1'b0;
  logic             a = 1'b0;
  logic             cfg_load = 1'b0;
  logic [7:0]       cfg_pattern = '0;
  logic [LEN_W-1:0] cfg_len = '0;
  logic             cfg_overlap = 1'b0;

  logic             y0, y1, err0, err1;
  logic [15:0]      hc0;
  logic [1:0]       hc1;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  seq_detector_param #(.MAX_LEN(MAX_LEN), .CNT_W(16)) u_dut_w (
    .clk(clk), .reset(reset), .en(en), .a(a), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .y(y0), .hit_count(hc0), .cfg_err(err0)
  );

  seq_detector_param #(.MAX_LEN(MAX_LEN), .CNT_W(2)) u_dut_n (
    .clk(clk), .reset(reset), .en(en), .a(a), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .y(y1), .hit_count(hc1), .cfg_err(err1)
  );

  // ---------------- reference model ----------------
  bit       m_uncfg = 1'b1;
  int       m_len   = 0;
  bit [7:0] m_pat   = '0;
  bit       m_ovl   = 1'b0;
  bit       m_y     = 1'b0;
  int       m_cnt   = 0;
  bit       m_err   = 1'b0;
  bit       m_q[$];          // bits eligible for the next match, oldest first

  function automatic void model_reset();
    m_uncfg = 1'b1; m_len = 0; m_pat = '0; m_ovl = 1'b0;
    m_y = 1'b0; m_cnt = 0; m_err = 1'b0; m_q.delete();
  endfunction

  function automatic void model_edge(bit l, bit e, bit b, bit [7:0] p, int ln, bit o);
    bit ok;
    if (l) begin
      m_pat = p; m_len = ln; m_ovl = o; m_q.delete(); m_cnt = 0; m_y = 1'b0;
      m_err   = (ln == 0 || ln > MAX_LEN);
      m_uncfg = m_err;
    end else if (e && !m_uncfg) begin
      m_q.push_back(b);
      if (m_q.size() > MAX_LEN) void'(m_q.pop_front());
      ok = (m_q.size() >= m_len);
      for (int k = 0; k < m_len; k++)
        if (ok && m_q[m_q.size()-1-k] != m_pat[k]) ok = 1'b0;
      m_y = ok;
      if (ok) begin
        m_cnt++;
        if (!m_ovl) m_q.delete();
      end
    end
  endfunction

  function automatic logic [31:0] sat(int v, int mx);
    return (v > mx) ? mx : v;
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".y"},     32'(y0),   32'(m_y));
    check({tag, ".y_n"},   32'(y1),   32'(m_y));
    check({tag, ".cnt"},   32'(hc0),  sat(m_cnt, 65535));
    check({tag, ".cnt_n"}, 32'(hc1),  sat(m_cnt, 3));
    check({tag, ".err"},   32'(err0), 32'(m_err));
    check({tag, ".err_n"}, 32'(err1), 32'(m_err));
  endtask

  // One clock: apply inputs, advance the model at the edge, check after it.
  task automatic cyc(input string tag, input bit l, input bit e, input bit b,
                     input bit [7:0] p, input int ln, input bit o);
    cfg_load = l; en = e; a = b; cfg_pattern = p; cfg_len = LEN_W'(ln); cfg_overlap = o;
    @(posedge clk);
    model_edge(l, e, b, p, ln, o);
    #1;
    check_all(tag);
  endtask

  task automatic load(input string tag, input bit [7:0] p, input int ln, input bit o);
    cyc(tag, 1'b1, 1'b0, 1'b0, p, ln, o);
  endtask

  task automatic feed(input string tag, input bit b);
    cyc(tag, 1'b0, 1'b1, b, cfg_pattern, int'(cfg_len), cfg_overlap);
  endtask

  // Asynchronous reset applied mid-cycle, held across two edges with activity.
  task automatic mid_reset(input string tag);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_all(tag);
    for (int i = 0; i < 2; i++) begin
      en = 1'b1; a = ~a;
      @(posedge clk);
      #1;
      check_all({tag, "_hold"});
    end
    reset = 1'b0;
  endtask

  initial begin
    // power-up reset
    #2 reset = 1'b1;
    #1 model_reset();
    check_all("por");
    @(posedge clk);
    #1 reset = 1'b0;

    // T2: len 2, pattern 01, non-overlap
    load("t2_load", 8'b01, 2, 1'b0);
    feed("t2", 1'b0); feed("t2", 1'b1); feed("t2", 1'b0); feed("t2", 1'b1);
    check("t2_cnt_const", 32'(hc0), 2);
    check("t2_y_const", 32'(y0), 1);

    // T1: partial stream then async reset; UNCFG ignores input afterwards
    feed("t1_pre", 1'b0);
    mid_reset("t1");
    feed("t1_uncfg", 1'b0); feed("t1_uncfg", 1'b1);
    check("t1_cnt_const", 32'(hc0), 0);

    // T3: len 3, pattern 101, overlap then non-overlap
    load("t3o_load", 8'b101, 3, 1'b1);
    feed("t3o", 1); feed("t3o", 0); feed("t3o", 1); feed("t3o", 0); feed("t3o", 1);
    check("t3o_cnt_const", 32'(hc0), 2);
    load("t3n_load", 8'b101, 3, 1'b0);
    feed("t3n", 1); feed("t3n", 0); feed("t3n", 1); feed("t3n", 0); feed("t3n", 1);
    check("t3n_cnt_const", 32'(hc0), 1);

    // T4: pattern 11 overlap, y high continuously; en=0 gap holds y
    load("t4_load", 8'b11, 2, 1'b1);
    feed("t4", 1); feed("t4", 1); feed("t4", 1); feed("t4", 1);
    check("t4_cnt_const", 32'(hc0), 3);
    cyc("t4_gap", 1'b0, 1'b0, 1'b0, 8'b11, 2, 1'b1);
    cyc("t4_gap", 1'b0, 1'b0, 1'b1, 8'b11, 2, 1'b1);
    check("t4_gap_y_const", 32'(y0), 1);

    // T5: invalid lengths set sticky error, valid load clears it
    load("t5_len0", 8'h00, 0, 1'b0);
    feed("t5_uncfg", 0); feed("t5_uncfg", 0);
    load("t5_len9", 8'hff, 9, 1'b1);
    check("t5_err_const", 32'(err0), 1);
    feed("t5_uncfg", 1); feed("t5_uncfg", 1);
    load("t5_ok", 8'h01, 1, 1'b0);
    check("t5_clr_const", 32'(err0), 0);

    // T6: len 1 pattern 1; narrow counter saturates at 3
    for (int i = 0; i < 5; i++) begin
      feed("t6", 1'b1);
      check("t6_sat_const", 32'(hc1), (i < 3) ? i + 1 : 3);
    end
    cyc("t6_load_en", 1'b1, 1'b1, 1'b1, 8'h01, 1, 1'b0);
    check("t6_cnt0_const", 32'(hc1), 0);

    // Randomized traffic with occasional reconfiguration and resets
    for (int i = 0; i < 1500; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 1) begin
        mid_reset("rnd_rst");
      end else if (r < 5) begin
        int ln;
        ln = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 9))
                                         : int'($urandom_range(1, MAX_LEN));
        load("rnd_load", 8'($urandom), ln, 1'($urandom));
      end else begin
        cyc("rnd", 1'b0, ($urandom_range(0, 9) < 7), 1'($urandom),
            cfg_pattern, int'(cfg_len), cfg_overlap);
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
